// File: rtl/debug_scan_slave.sv
// Responder end of the debug serial link: oversamples sclk/ssel/sin and runs a capture-shift-commit
// transaction per ssel frame. Optional even-parity frame bit enabled by DEBUG_SCAN_PARITY_EN.
module debug_scan_slave #(
  parameter int D_WIDTH  = 8,
  parameter int NUM_REGS = 7
) (
  input  logic                        clk_int,
  input  logic                        reset,
  input  logic                        sclk,
  input  logic                        ssel,
  input  logic                        sin,
  input  logic [2:0]                  saddr,
  output logic                        sout,
  input  logic [D_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*D_WIDTH-1:0] cfg_out,
  output logic                        commit,
  output logic                        frame_err
`ifdef DEBUG_SCAN_PARITY_EN
  ,
  output logic                        parity_err
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

`ifdef DEBUG_SCAN_PARITY_EN
  localparam logic [3:0] DATA_LEN  = 4'(D_WIDTH);
  localparam logic [3:0] FRAME_LEN = 4'(D_WIDTH + 1);
`else
  localparam logic [3:0] FRAME_LEN = 4'(D_WIDTH);
`endif

  state_t               state_q, state_d;
  logic [D_WIDTH-1:0]   regs [NUM_REGS];
  logic [D_WIDTH-1:0]   shreg;
  logic [D_WIDTH-1:0]   cap_val;
  logic [3:0]           bit_cnt;
  logic [2:0]           addr_q;
  logic                 pend_q;
  logic                 sclk_s1, sclk_s2, sclk_prev;
  logic                 ssel_s1, ssel_s2, ssel_prev;
  logic                 sin_s1, sin_s2;
  logic                 sclk_rise, ssel_rise, ssel_fall;
  logic                 addr_ok;
  logic                 capture, do_shift, do_write, set_ferr;
`ifdef DEBUG_SCAN_PARITY_EN
  logic                 par_q;
  logic                 set_perr;
`endif

  assign sclk_rise = sclk_s2 & ~sclk_prev;
  assign ssel_rise = ssel_s2 & ~ssel_prev;
  assign ssel_fall = ~ssel_s2 & ssel_prev;
  assign addr_ok   = (addr_q != 3'd7) && ({1'b0, addr_q} < 4'(NUM_REGS));

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    assign cfg_out[g*D_WIDTH +: D_WIDTH] = regs[g];
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    do_shift = 1'b0;
    do_write = 1'b0;
    set_ferr = 1'b0;
`ifdef DEBUG_SCAN_PARITY_EN
    set_perr = 1'b0;
`endif
    cap_val  = '0;
    if (saddr == 3'd7) cap_val = status_in;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (saddr == 3'(i)) cap_val = regs[i];
    end

    case (state_q)
      IDLE: begin
        // A rise seen during COMMIT is honoured here if ssel is still high.
        if (ssel_rise || (pend_q && ssel_s2)) begin
          capture = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = sclk_rise;
        if (ssel_fall) state_d = COMMIT;
      end
      COMMIT: begin
        if (bit_cnt == FRAME_LEN) begin
`ifdef DEBUG_SCAN_PARITY_EN
          if ((^shreg) == par_q) do_write = addr_ok;
          else                   set_perr = 1'b1;
`else
          do_write = addr_ok;
`endif
        end else if (bit_cnt != 4'd0) begin
          set_ferr = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_int) begin
    if (reset) begin
      // ssel chain resets high so a frame already open at reset release produces no rise.
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      ssel_s1   <= 1'b1;
      ssel_s2   <= 1'b1;
      ssel_prev <= 1'b1;
      sin_s1    <= 1'b0;
      sin_s2    <= 1'b0;
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      addr_q    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      sout      <= 1'b0;
      commit    <= 1'b0;
      frame_err <= 1'b0;
      // NOTE: the register bank is architecturally visible, so it is reset explicitly.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
`ifdef DEBUG_SCAN_PARITY_EN
      par_q      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sclk_s1   <= sclk;
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      ssel_s1   <= ssel;
      ssel_s2   <= ssel_s1;
      ssel_prev <= ssel_s2;
      sin_s1    <= sin;
      sin_s2    <= sin_s1;

      state_q <= state_d;
      pend_q  <= (state_q == COMMIT) && ssel_rise;
      commit  <= do_write;

      if (capture) begin
        addr_q  <= saddr;
        shreg   <= cap_val;
        bit_cnt <= '0;
      end else if (do_shift) begin
`ifdef DEBUG_SCAN_PARITY_EN
        if (bit_cnt < DATA_LEN)       shreg <= {shreg[D_WIDTH-2:0], sin_s2};
        else if (bit_cnt == DATA_LEN) par_q <= sin_s2;
`else
        shreg <= {shreg[D_WIDTH-2:0], sin_s2};
`endif
        if (bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
      end

      if (do_write) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (addr_q == 3'(i)) regs[i] <= shreg;
        end
      end

      if (set_ferr) frame_err <= 1'b1;
`ifdef DEBUG_SCAN_PARITY_EN
      if (set_perr) parity_err <= 1'b1;
`endif
      sout <= (state_q == IDLE) ? 1'b0 : shreg[D_WIDTH-1];
    end
  end

endmodule
